// File: rtl/switch_debounce_3.sv
`default_nettype none
// =============================================================================
//  Module      : switch_debounce_3
//  Description : Three-channel synchroniser + debouncer with rise/fall ticks.
//  Revision    : 1.0 - initial release
// =============================================================================

module switch_debounce_3 #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 500000,
   parameter int CNT_W       = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] sw_raw,
   output logic [2:0] db_level,
   output logic [2:0] rise_tick,
   output logic [2:0] fall_tick
);

   typedef enum logic [1:0] {
      ST_ZERO  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_ONE   = 2'd2,
      ST_WAIT0 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_COUNT - 1);

   if ((SYNC_STAGES < 2) || (DB_COUNT < 1) ||
       ((CNT_W < 31) && ((1 << CNT_W) <= DB_COUNT))) begin : g_param_err
      $error("switch_debounce_3: illegal SYNC_STAGES/DB_COUNT/CNT_W combination");
   end

   for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_nxt;
      logic                   r_db;
      logic                   r_rise;
      logic                   r_fall;
      logic                   w_rise_nxt;
      logic                   w_fall_nxt;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw[i]};
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_rise_nxt  = 1'b0;
         w_fall_nxt  = 1'b0;
         case (r_state)
            ST_ZERO: begin
               if (w_s) begin
                  w_state_nxt = ST_WAIT1;
                  w_cnt_nxt   = '0;
               end
            end
            ST_WAIT1: begin
               if (!w_s) begin
                  w_state_nxt = ST_ZERO;
               end else if (r_cnt == c_cnt_last) begin
                  w_state_nxt = ST_ONE;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_ONE: begin
               if (!w_s) begin
                  w_state_nxt = ST_WAIT0;
                  w_cnt_nxt   = '0;
               end
            end
            ST_WAIT0: begin
               if (w_s) begin
                  w_state_nxt = ST_ONE;
               end else if (r_cnt == c_cnt_last) begin
                  w_state_nxt = ST_ZERO;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_ZERO;
            end
         endcase
      end

      // db_level is derived from the next state so level and tick appear together
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state <= ST_ZERO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= (w_state_nxt == ST_ONE) || (w_state_nxt == ST_WAIT0);
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
         end
      end

      assign db_level[i]  = r_db;
      assign rise_tick[i] = r_rise;
      assign fall_tick[i] = r_fall;
   end

endmodule

`default_nettype wire
